inst_rom_arb: RTL and testbench

- Arbitrates the single-read-port instruction ROM between two requesters: the IF-stage fetch port (fet_*) and a MEM-stage data-read port (dat_*) used for loads from code space.
- Issues at most one ROM read per cycle and tracks ROM read latency.
- Routes each returned word to the requester that owns it.
- Asserts a stall request toward the pipeline controller while a fetch is waiting.

---
 rtl/inst_rom_arb.sv | 121 ++++++++++++
 tb/tb_inst_rom_arb.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_arb.sv
// Arbiter for the single-read-port instruction ROM, shared by the IF-stage fetch port and the MEM-stage data port.
// Define INST_ROM_ARB_STATS_EN to build the saturating conflict and forced-grant counters.
module inst_rom_arb #(
    parameter int ROM_LATENCY = 1,
    parameter int MAX_WAIT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fet_req,
    input  logic [31:0] fet_addr,
    output logic        fet_gnt,
    output logic        fet_rvalid,
    output logic [31:0] fet_rdata,
    input  logic        dat_req,
    input  logic [31:0] dat_addr,
    output logic        dat_gnt,
    output logic        dat_rvalid,
    output logic [31:0] dat_rdata,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    output logic        stallreq_if,
    output logic [15:0] stat_conflict,
    output logic [15:0] stat_force
);

    typedef enum logic {ARB_NORM, ARB_FORCE} arb_state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_FET, OWN_DAT} own_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    arb_state_t state, state_next;
    logic [3:0] wait_cnt, wait_cnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_NORM;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Force fetch in the cycle right after its MAX_WAIT-th consecutive denial.
    always_comb begin
        wait_cnt_next = (fet_req && !fet_gnt) ? wait_cnt + 4'd1 : 4'd0;
        state_next    = ARB_NORM;
        if (state == ARB_NORM && wait_cnt_next == MAX_WAIT_C)
            state_next = ARB_FORCE;
    end

    always_comb begin
        fet_gnt = 1'b0;
        dat_gnt = 1'b0;
        if (!rst) begin
            if (fet_req && (!dat_req || state == ARB_FORCE))
                fet_gnt = 1'b1;
            else if (dat_req)
                dat_gnt = 1'b1;
        end
        rom_ce      = fet_gnt | dat_gnt;
        rom_addr    = fet_gnt ? fet_addr : (dat_gnt ? dat_addr : 32'd0);
        stallreq_if = fet_req & ~fet_gnt & ~rst;
    end

    generate
        if (ROM_LATENCY == 0) begin : g_lat0
            always_comb begin
                fet_rvalid = fet_gnt;
                dat_rvalid = dat_gnt;
                fet_rdata  = fet_gnt ? rom_inst : 32'd0;
                dat_rdata  = dat_gnt ? rom_inst : 32'd0;
            end
        end else begin : g_lat1
            own_t resp_own;

            always_ff @(posedge clk) begin
                if (rst)
                    resp_own <= OWN_NONE;
                else if (fet_gnt)
                    resp_own <= OWN_FET;
                else if (dat_gnt)
                    resp_own <= OWN_DAT;
                else
                    resp_own <= OWN_NONE;
            end

            // Gate with rst so a response in flight at reset never surfaces.
            always_comb begin
                fet_rvalid = !rst && resp_own == OWN_FET;
                dat_rvalid = !rst && resp_own == OWN_DAT;
                fet_rdata  = fet_rvalid ? rom_inst : 32'd0;
                dat_rdata  = dat_rvalid ? rom_inst : 32'd0;
            end
        end
    endgenerate

`ifdef INST_ROM_ARB_STATS_EN
    logic [15:0] conflict_q, force_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= 16'd0;
            force_q    <= 16'd0;
        end else begin
            if (fet_req && dat_req && conflict_q != 16'hFFFF)
                conflict_q <= conflict_q + 16'd1;
            if ((fet_gnt || dat_gnt) && state == ARB_FORCE && force_q != 16'hFFFF)
                force_q <= force_q + 16'd1;
        end
    end

    assign stat_conflict = conflict_q;
    assign stat_force    = force_q;
`else
    assign stat_conflict = 16'd0;
    assign stat_force    = 16'd0;
`endif

endmodule

// File: tb/tb_inst_rom_arb.sv
// Self-checking bench for inst_rom_arb: a registered-ROM instance and a combinational-ROM instance share one stimulus.
module tb_inst_rom_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fet_req = 1'b0, dat_req = 1'b0;
    logic [31:0] fet_addr = 32'd0, dat_addr = 32'd0;

    logic        fet_gnt1, fet_rvalid1, dat_gnt1, dat_rvalid1, rom_ce1, stall1;
    logic [31:0] fet_rdata1, dat_rdata1, rom_addr1, rom_inst1;
    logic [15:0] sconf1, sforc1;
    logic        fet_gnt0, fet_rvalid0, dat_gnt0, dat_rvalid0, rom_ce0, stall0;
    logic [31:0] fet_rdata0, dat_rdata0, rom_addr0, rom_inst0;
    logic [15:0] sconf0, sforc0;

    int tests = 0, fails = 0;

    localparam int MAXW = 4;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0:   rom_word = 32'h34011100;
            32'h4:   rom_word = 32'h34020020;
            32'h8:   rom_word = 32'h3403ff00;
            default: rom_word = {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1234};
        endcase
    endfunction

    inst_rom_arb #(.ROM_LATENCY(1), .MAX_WAIT(MAXW)) dut1 (
        .clk(clk), .rst(rst),
        .fet_req(fet_req), .fet_addr(fet_addr), .fet_gnt(fet_gnt1),
        .fet_rvalid(fet_rvalid1), .fet_rdata(fet_rdata1),
        .dat_req(dat_req), .dat_addr(dat_addr), .dat_gnt(dat_gnt1),
        .dat_rvalid(dat_rvalid1), .dat_rdata(dat_rdata1),
        .rom_ce(rom_ce1), .rom_addr(rom_addr1), .rom_inst(rom_inst1),
        .stallreq_if(stall1), .stat_conflict(sconf1), .stat_force(sforc1)
    );

    inst_rom_arb #(.ROM_LATENCY(0), .MAX_WAIT(MAXW)) dut0 (
        .clk(clk), .rst(rst),
        .fet_req(fet_req), .fet_addr(fet_addr), .fet_gnt(fet_gnt0),
        .fet_rvalid(fet_rvalid0), .fet_rdata(fet_rdata0),
        .dat_req(dat_req), .dat_addr(dat_addr), .dat_gnt(dat_gnt0),
        .dat_rvalid(dat_rvalid0), .dat_rdata(dat_rdata0),
        .rom_ce(rom_ce0), .rom_addr(rom_addr0), .rom_inst(rom_inst0),
        .stallreq_if(stall0), .stat_conflict(sconf0), .stat_force(sforc0)
    );

    // ROM models: registered output for dut1, combinational for dut0.
    logic [31:0] rom_q = 32'd0;
    always @(posedge clk) if (rom_ce1) rom_q <= rom_word(rom_addr1);
    assign rom_inst1 = rom_q;
    assign rom_inst0 = rom_word(rom_addr0);

    // Reference model state
    int          m_denied = 0;
    bit          m_forced = 0;
    bit          m_pend_v = 0, m_pend_fet = 0;
    logic [31:0] m_pend_addr = 32'd0;
    int          m_conf = 0, m_forc = 0;

    // Expected values for the current cycle
    bit          e_fgnt, e_dgnt, e_stall, e_fv1, e_dv1, e_fv0, e_dv0;
    logic [31:0] e_addr, e_fd1, e_dd1, e_fd0, e_dd0;
    logic [15:0] e_sconf, e_sforc;

    task automatic eval();
        e_fgnt = 0; e_dgnt = 0;
        if (!rst) begin
            e_fgnt = fet_req && (!dat_req || m_forced);
            e_dgnt = dat_req && !e_fgnt;
        end
        e_addr  = e_fgnt ? fet_addr : (e_dgnt ? dat_addr : 32'd0);
        e_stall = !rst && fet_req && !e_fgnt;
        e_fv1 = !rst && m_pend_v && m_pend_fet;
        e_dv1 = !rst && m_pend_v && !m_pend_fet;
        e_fd1 = e_fv1 ? rom_word(m_pend_addr) : 32'd0;
        e_dd1 = e_dv1 ? rom_word(m_pend_addr) : 32'd0;
        e_fv0 = e_fgnt;
        e_dv0 = e_dgnt;
        e_fd0 = e_fgnt ? rom_word(fet_addr) : 32'd0;
        e_dd0 = e_dgnt ? rom_word(dat_addr) : 32'd0;
`ifdef INST_ROM_ARB_STATS_EN
        e_sconf = 16'(m_conf);
        e_sforc = 16'(m_forc);
`else
        e_sconf = 16'd0;
        e_sforc = 16'd0;
`endif
    endtask

    task automatic commit();
        if (rst) begin
            m_denied = 0; m_forced = 0; m_pend_v = 0; m_conf = 0; m_forc = 0;
        end else begin
            if (fet_req && dat_req && m_conf < 65535) m_conf++;
            if (m_forced && (e_fgnt || e_dgnt) && m_forc < 65535) m_forc++;
            m_denied   = (fet_req && !e_fgnt) ? m_denied + 1 : 0;
            m_forced   = (m_denied == MAXW);
            m_pend_v   = e_fgnt || e_dgnt;
            m_pend_fet = e_fgnt;
            m_pend_addr = e_addr;
        end
    endtask

    task automatic cycle(input logic r, input logic fr, input logic [31:0] fa,
                         input logic dr, input logic [31:0] da);
        commit();
        @(posedge clk);
        #1;
        rst = r; fet_req = fr; fet_addr = fa; dat_req = dr; dat_addr = da;
        #1;
        eval();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 32'h100, 1, 32'h200);
            tests++;
            if ({fet_gnt1, dat_gnt1, fet_rvalid1, dat_rvalid1, rom_ce1, stall1,
                 fet_gnt0, dat_gnt0, fet_rvalid0, dat_rvalid0, rom_ce0} !== 11'b0) begin
                fails++;
                $display("[TB] FAIL reset_outputs cycle %0d: got %b%b%b%b%b%b %b%b%b%b%b want all 0", i,
                         fet_gnt1, dat_gnt1, fet_rvalid1, dat_rvalid1, rom_ce1, stall1,
                         fet_gnt0, dat_gnt0, fet_rvalid0, dat_rvalid0, rom_ce0);
            end
            tests++;
            if ({rom_addr1, fet_rdata1, dat_rdata1} !== 96'd0) begin
                fails++;
                $display("[TB] FAIL reset_data cycle %0d: rom_addr=%h fet_rdata=%h dat_rdata=%h want 0",
                         i, rom_addr1, fet_rdata1, dat_rdata1);
            end
        end
        cycle(0, 1, 32'h100, 1, 32'h200);
        tests++;
        if (dat_gnt1 !== 1'b1 || fet_gnt1 !== 1'b0 || rom_addr1 !== 32'h200) begin
            fails++;
            $display("[TB] FAIL reset_release: dat_gnt=%b fet_gnt=%b rom_addr=%h want 1 0 00000200",
                     dat_gnt1, fet_gnt1, rom_addr1);
        end
    endtask

    task automatic test_fetch_only();
        logic [31:0] words [3];
        words[0] = 32'h34011100; words[1] = 32'h34020020; words[2] = 32'h3403ff00;
        cycle(1, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            if (k <= 3) cycle(0, 1, 32'(4 * (k - 1)), 0, 0);
            else        cycle(0, 0, 0, 0, 0);
            tests++;
            if (fet_gnt1 !== (k <= 3) || stall1 !== 1'b0) begin
                fails++;
                $display("[TB] FAIL fetch_gnt cycle %0d: fet_gnt=%b stall=%b want %b 0", k, fet_gnt1, stall1, k <= 3);
            end
            tests++;
            if (fet_rvalid1 !== (k >= 2 && k <= 4) || dat_rvalid1 !== 1'b0 ||
                (k >= 2 && k <= 4 && fet_rdata1 !== words[k-2])) begin
                fails++;
                $display("[TB] FAIL fetch_resp cycle %0d: fet_rvalid=%b fet_rdata=%h dat_rvalid=%b want %b %h 0",
                         k, fet_rvalid1, fet_rdata1, dat_rvalid1, k >= 2 && k <= 4,
                         (k >= 2 && k <= 4) ? words[k-2] : 32'd0);
            end
        end
    endtask

    task automatic test_contention();
        cycle(1, 0, 0, 0, 0);
        for (int i = 1; i <= 7; i++) begin
            cycle(0, 1, 32'h40, 1, 32'h80);
            tests++;
            if (dat_gnt1 !== (i % 5 != 0) || fet_gnt1 !== (i % 5 == 0) || stall1 !== (i % 5 != 0)) begin
                fails++;
                $display("[TB] FAIL contention cycle %0d: dat_gnt=%b fet_gnt=%b stall=%b want %b %b %b",
                         i, dat_gnt1, fet_gnt1, stall1, i % 5 != 0, i % 5 == 0, i % 5 != 0);
            end
        end
    endtask

    task automatic test_lat0();
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 32'h10);
        tests++;
        if (dat_rvalid0 !== 1'b1 || dat_rdata0 !== 32'hBEFF1234 || fet_rdata0 !== 32'd0 || fet_rvalid0 !== 1'b0) begin
            fails++;
            $display("[TB] FAIL lat0_data: dat_rvalid=%b dat_rdata=%h fet_rvalid=%b fet_rdata=%h want 1 beff1234 0 0",
                     dat_rvalid0, dat_rdata0, fet_rvalid0, fet_rdata0);
        end
    endtask

    task automatic test_reset_mid();
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 32'h20, 0, 0);
        tests++;
        if (fet_gnt1 !== 1'b1) begin
            fails++;
            $display("[TB] FAIL rstmid_gnt: fet_gnt=%b want 1", fet_gnt1);
        end
        cycle(1, 0, 0, 0, 0);
        tests++;
        if (fet_rvalid1 !== 1'b0 || fet_rdata1 !== 32'd0) begin
            fails++;
            $display("[TB] FAIL rstmid_n1: fet_rvalid=%b fet_rdata=%h want 0 0", fet_rvalid1, fet_rdata1);
        end
        cycle(0, 0, 0, 0, 0);
        tests++;
        if (fet_rvalid1 !== 1'b0 || dat_rvalid1 !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rstmid_n2: fet_rvalid=%b dat_rvalid=%b want 0 0", fet_rvalid1, dat_rvalid1);
        end
    endtask

    task automatic test_stats();
        logic [15:0] wc, wf;
`ifdef INST_ROM_ARB_STATS_EN
        wc = 16'd10; wf = 16'd2;
`else
        wc = 16'd0; wf = 16'd0;
`endif
        cycle(1, 1, 32'h4, 1, 32'h8);
        for (int i = 0; i < 10; i++) cycle(0, 1, 32'h4, 1, 32'h8);
        cycle(0, 0, 0, 0, 0);
        tests++;
        if (sconf1 !== wc || sforc1 !== wf || sconf0 !== wc || sforc0 !== wf) begin
            fails++;
            $display("[TB] FAIL stats: conflict=%0d/%0d force=%0d/%0d want %0d %0d",
                     sconf1, sconf0, sforc1, sforc0, wc, wf);
        end
    endtask

    task automatic test_random();
        logic        fr, dr, r;
        logic [31:0] fa, da;
        fr = 0; dr = 0; fa = 0; da = 0;
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            // Pending requests are usually held with a stable address; occasionally dropped.
            if (fet_req && !e_fgnt) fr = ($urandom_range(9) != 0);
            else begin fr = $urandom_range(1); fa = $urandom & 32'h0000_FFFF; end
            if (dat_req && !e_dgnt) dr = ($urandom_range(9) != 0);
            else begin dr = $urandom_range(1); da = $urandom; end
            r = ($urandom_range(49) == 0);
            cycle(r, fr, fa, dr, da);
            tests++;
            if ({fet_gnt1, dat_gnt1, rom_ce1, stall1, rom_addr1} !== {e_fgnt, e_dgnt, e_fgnt | e_dgnt, e_stall, e_addr} ||
                {fet_gnt0, dat_gnt0, rom_ce0, stall0, rom_addr0} !== {e_fgnt, e_dgnt, e_fgnt | e_dgnt, e_stall, e_addr}) begin
                fails++;
                $display("[TB] FAIL rand_arb %0d: gnt f/d=%b%b ce=%b stall=%b addr=%h want %b%b %b %b %h",
                         i, fet_gnt1, dat_gnt1, rom_ce1, stall1, rom_addr1, e_fgnt, e_dgnt, e_fgnt | e_dgnt, e_stall, e_addr);
            end
            tests++;
            if ({fet_rvalid1, dat_rvalid1, fet_rdata1, dat_rdata1} !== {e_fv1, e_dv1, e_fd1, e_dd1}) begin
                fails++;
                $display("[TB] FAIL rand_lat1 %0d: rvalid f/d=%b%b rdata=%h/%h want %b%b %h/%h",
                         i, fet_rvalid1, dat_rvalid1, fet_rdata1, dat_rdata1, e_fv1, e_dv1, e_fd1, e_dd1);
            end
            tests++;
            if ({fet_rvalid0, dat_rvalid0, fet_rdata0, dat_rdata0} !== {e_fv0, e_dv0, e_fd0, e_dd0}) begin
                fails++;
                $display("[TB] FAIL rand_lat0 %0d: rvalid f/d=%b%b rdata=%h/%h want %b%b %h/%h",
                         i, fet_rvalid0, dat_rvalid0, fet_rdata0, dat_rdata0, e_fv0, e_dv0, e_fd0, e_dd0);
            end
            tests++;
            if (sconf1 !== e_sconf || sforc1 !== e_sforc) begin
                fails++;
                $display("[TB] FAIL rand_stats %0d: conflict=%0d force=%0d want %0d %0d",
                         i, sconf1, sforc1, e_sconf, e_sforc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_contention();
        test_lat0();
        test_reset_mid();
        test_stats();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
